row_read_sequencer: RTL

- Read-side scheduler for the 12 RGB and 12 mask line buffers of the background-removal pipeline.
- Tracks which buffer slots hold a complete RGB row and a complete mask row, and reads slots in strict round-robin order (0..11).
- For each slot, drives the paired RGB/mask read enables in lockstep and streams pixel+mask out over a valid/ready handshake.
- Pulses o_FINISH_PROCESS_1_ROW when a row has been fully consumed, so the input checker can admit the next row.

---
 rtl/row_read_sequencer_pkg.sv | 17 +
 rtl/rrs_skid_fifo2.sv | 48 ++++
 rtl/row_read_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/row_read_sequencer_pkg.sv
// Shared types and sizing for the background-removal row read sequencer.
package bgr_pkg;

    localparam int unsigned NUM_BUFF_C  = 12;
    localparam int unsigned ROW_WIDTH_C = 320;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned CNT_W       = $clog2(ROW_WIDTH_C + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/rrs_skid_fifo2.sv
// Two-entry FIFO decoupling line-buffer read latency from downstream backpressure.
module rrs_skid_fifo2 #(
    parameter int unsigned WIDTH = 25
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop & (r_count != 2'd0);
    assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/row_read_sequencer.sv
// Round-robin reader for paired RGB/mask line buffers, streaming {mask, pixel} downstream.
// Define BGR_MASK_APPLY_EN to zero background pixels on o_DATA.
module row_read_sequencer
    import bgr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_BUFF   = NUM_BUFF_C,
    parameter int unsigned ROW_WIDTH  = ROW_WIDTH_C
) (
    input  logic                           i_CLK,
    input  logic                           i_RSTn,
    input  logic [NUM_BUFF-1:0]            i_RGB_INTR,
    input  logic [NUM_BUFF-1:0]            i_MASK_INTR,
    output logic [NUM_BUFF-1:0]            o_RGB_READ,
    output logic [NUM_BUFF-1:0]            o_MASK_READ,
    input  logic [NUM_BUFF*DATA_WIDTH-1:0] i_RGB_DATA,
    input  logic [NUM_BUFF-1:0]            i_MASK_DATA,
    output logic [DATA_WIDTH-1:0]          o_DATA,
    output logic                           o_MASK,
    output logic                           o_VALID,
    input  logic                           i_READY,
    output logic                           o_FINISH_PROCESS_1_ROW,
    output logic [IDX_W-1:0]               o_ROW_IDX,
    output logic                           o_BUSY
);

    state_t                r_state;
    state_t                w_next;
    logic [NUM_BUFF-1:0]   r_rgb_rdy;
    logic [NUM_BUFF-1:0]   r_mask_rdy;
    logic [NUM_BUFF-1:0]   w_sel;
    logic [NUM_BUFF-1:0]   w_clr;
    logic [IDX_W-1:0]      r_ptr;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      r_acc_cnt;
    logic                  r_inflight;
    logic                  w_rd_en;
    logic                  w_done;
    logic                  w_pop;
    logic                  w_slot_rdy;
    logic                  w_fifo_valid;
    logic [1:0]            w_fifo_cnt;
    logic [2:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_pix_in;
    logic                  w_mask_in;
    logic [DATA_WIDTH:0]   w_fifo_q;

    // Current-slot decode and read-data mux.
    always_comb begin
        w_sel     = '0;
        w_pix_in  = '0;
        w_mask_in = 1'b0;
        for (int k = 0; k < NUM_BUFF; k++) begin
            if (r_ptr == IDX_W'(k)) begin
                w_sel[k]  = 1'b1;
                w_pix_in  = i_RGB_DATA[k*DATA_WIDTH +: DATA_WIDTH];
                w_mask_in = i_MASK_DATA[k];
            end
        end
    end

    assign w_slot_rdy = |(w_sel & r_rgb_rdy & r_mask_rdy);
    assign w_pop      = w_fifo_valid & i_READY;
    assign w_occ      = 3'(w_fifo_cnt) + 3'(r_inflight);
    assign w_clr      = w_done ? w_sel : '0;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Occupancy counts the in-flight read so the FIFO can never overflow.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE:     w_next = WAIT_ROW;
            WAIT_ROW: if (w_slot_rdy) w_next = READ;
            READ: begin
                if ((w_occ < (3'd2 + 3'(w_pop))) && (r_rd_cnt < CNT_W'(ROW_WIDTH))) begin
                    w_rd_en = 1'b1;
                    if (r_rd_cnt == CNT_W'(ROW_WIDTH - 1)) w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_fifo_valid && !r_inflight && (r_acc_cnt == CNT_W'(ROW_WIDTH))) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = WAIT_ROW;
            end
            default:  w_next = IDLE;
        endcase
    end

    // Ready flags (set wins over clear), slot pointer and row counters.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_rgb_rdy  <= '0;
            r_mask_rdy <= '0;
            r_ptr      <= '0;
            r_rd_cnt   <= '0;
            r_acc_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_rgb_rdy  <= (r_rgb_rdy & ~w_clr) | i_RGB_INTR;
            r_mask_rdy <= (r_mask_rdy & ~w_clr) | i_MASK_INTR;
            if (w_done) begin
                r_rd_cnt  <= '0;
                r_acc_cnt <= '0;
                r_ptr     <= (r_ptr == IDX_W'(NUM_BUFF - 1)) ? '0 : r_ptr + IDX_W'(1);
            end else begin
                if (w_rd_en) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                if (w_pop)   r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
        end
    end

    rrs_skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_RSTn  (i_RSTn),
        .i_push  (r_inflight),
        .i_data  ({w_mask_in, w_pix_in}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_cnt)
    );

    assign o_RGB_READ             = w_rd_en ? w_sel : '0;
    assign o_MASK_READ            = w_rd_en ? w_sel : '0;
    assign o_VALID                = w_fifo_valid;
    assign o_MASK                 = w_fifo_q[DATA_WIDTH];
    assign o_FINISH_PROCESS_1_ROW = w_done;
    assign o_ROW_IDX              = r_ptr;
    assign o_BUSY                 = (r_state == READ) || (r_state == DRAIN);

`ifdef BGR_MASK_APPLY_EN
    assign o_DATA = w_fifo_q[DATA_WIDTH] ? w_fifo_q[DATA_WIDTH-1:0] : '0;
`else
    assign o_DATA = w_fifo_q[DATA_WIDTH-1:0];
`endif

endmodule
